// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU; single-cycle logic/add/sub/shift ops, WIDTH-cycle shift-add MUL and restoring DIV.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       aluOpcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] aluResult,
    output logic [WIDTH-1:0] aluResultHi,
    output logic             Zero,
    output logic             Carry,
    output logic             Error
);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] b_r, hi, lo, res, hi_n, lo_n;
    logic [3:0]       op_r;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   sum, dif, shl, madd, rem, rem_d;
    logic [SW-1:0]    sh;
    logic             cy, ill, ge, div0, iter;

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign sh        = B[SW-1:0];
    assign ill       = aluOpcode > 4'd9;
    assign div0      = aluOpcode == 4'd4 && B == '0;
    assign iter      = aluOpcode == 4'd3 || (aluOpcode == 4'd4 && !div0);

    always_comb begin
        sum = {1'b0, A} + {1'b0, B};
        dif = {1'b0, A} - {1'b0, B};
        shl = {1'b0, A} << sh;
        case (aluOpcode)
            4'd0:    res = A & B;
            4'd1:    res = A | B;
            4'd2:    res = sum[WIDTH-1:0];
            4'd5:    res = dif[WIDTH-1:0];
            4'd6:    res = ~(A | B);
            4'd7:    res = A ^ B;
            4'd8:    res = shl[WIDTH-1:0];
            4'd9:    res = A >> sh;
            default: res = '0;
        endcase
        cy = aluOpcode == 4'd2 ? sum[WIDTH] :
             aluOpcode == 4'd5 ? dif[WIDTH] :
             aluOpcode == 4'd8 ? shl[WIDTH] : 1'b0;
        // MUL: hi:lo is the product register, lo initially holds the multiplier
        madd  = {1'b0, hi} + (lo[0] ? {1'b0, b_r} : '0);
        // DIV: hi is the partial remainder, lo shifts dividend bits out and quotient bits in
        rem   = {hi, lo[WIDTH-1]};
        ge    = rem >= {1'b0, b_r};
        rem_d = ge ? rem - {1'b0, b_r} : rem;
        hi_n  = op_r == 4'd3 ? madd[WIDTH:1] : rem_d[WIDTH-1:0];
        lo_n  = op_r == 4'd3 ? {madd[0], lo[WIDTH-1:1]} : {lo[WIDTH-2:0], ge};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            b_r         <= '0;
            hi          <= '0;
            lo          <= '0;
            op_r        <= '0;
            cnt         <= '0;
            aluResult   <= '0;
            aluResultHi <= '0;
            Zero        <= 1'b0;
            Carry       <= 1'b0;
            Error       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op_r <= aluOpcode;
                    b_r  <= B;
                    lo   <= A;
                    hi   <= '0;
                    cnt  <= '0;
                    if (iter) begin
                        state <= BUSY;
                    end else begin
                        state       <= DONE;
                        aluResult   <= div0 ? '1 : res;
                        aluResultHi <= div0 ? A : '0;
                        Zero        <= div0 ? 1'b0 : res == '0;
                        Carry       <= div0 ? 1'b0 : cy;
                        Error       <= div0 | ill;
                    end
                end
                BUSY: begin
                    hi  <= hi_n;
                    lo  <= lo_n;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state       <= DONE;
                        aluResult   <= lo_n;
                        aluResultHi <= hi_n;
                        Zero        <= lo_n == '0;
                        Carry       <= op_r == 4'd3 && hi_n != '0;
                        Error       <= 1'b0;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed-vector bench for alu_seq at WIDTH = 8.
module tb_alu_seq;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] A = '0;
    logic [7:0] B = '0;
    logic [3:0] aluOpcode = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] aluResult;
    logic [7:0] aluResultHi;
    logic       Zero;
    logic       Carry;
    logic       Error;
    int         checks = 0;
    int         errors = 0;
    int         lat, rdy, seen;

    alu_seq #(.WIDTH(8)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .aluOpcode(aluOpcode), .out_valid(out_valid), .out_ready(out_ready),
        .aluResult(aluResult), .aluResultHi(aluResultHi), .Zero(Zero), .Carry(Carry), .Error(Error)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one request for exactly the accept edge, then scramble the inputs
    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        @(negedge clock);
        aluOpcode = op;
        A = a;
        B = b;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        A = 8'h55;
        B = 8'hAA;
        aluOpcode = 4'd1;
    endtask

    // Latency 1 means out_valid is already high right after the accept edge
    task automatic wait_done(output int l, output int r);
        l = 1;
        r = 0;
        while (!out_valid && l < 40) begin
            if (in_ready) r++;
            @(posedge clock);
            #1;
            l++;
        end
    endtask

    task automatic drain();
        @(posedge clock);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_result", {aluResultHi, aluResult}, 0);
        check("rst_flags", {Zero, Carry, Error}, 0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);

        issue(4'd2, 8'hF0, 8'h20);
        wait_done(lat, rdy);
        check("add_lat", lat, 1);
        check("add_res", aluResult, 8'h10);
        check("add_hi", aluResultHi, 8'h00);
        check("add_flags", {Zero, Carry, Error}, 3'b010);
        drain();
        check("add_idle", in_ready, 1);

        issue(4'd3, 8'h10, 8'h10);
        wait_done(lat, rdy);
        check("mul_lat", lat, 9);
        check("mul_busy_ready", rdy, 0);
        check("mul_res", aluResult, 8'h00);
        check("mul_hi", aluResultHi, 8'h01);
        check("mul_flags", {Zero, Carry, Error}, 3'b110);
        drain();

        issue(4'd3, 8'hD7, 8'h0B);
        wait_done(lat, rdy);
        check("mul2_prod", {aluResultHi, aluResult}, 16'h093D);
        check("mul2_flags", {Zero, Carry, Error}, 3'b010);
        drain();

        issue(4'd4, 8'd100, 8'd7);
        wait_done(lat, rdy);
        check("div_lat", lat, 9);
        check("div_quo", aluResult, 8'd14);
        check("div_rem", aluResultHi, 8'd2);
        check("div_err", Error, 0);
        drain();

        issue(4'd4, 8'd5, 8'd0);
        wait_done(lat, rdy);
        check("div0_lat", lat, 1);
        check("div0_res", aluResult, 8'hFF);
        check("div0_hi", aluResultHi, 8'd5);
        check("div0_err", Error, 1);
        drain();

        issue(4'd8, 8'h81, 8'h01);
        wait_done(lat, rdy);
        check("shl_res", aluResult, 8'h02);
        check("shl_carry", Carry, 1);
        drain();

        issue(4'd9, 8'h81, 8'h03);
        wait_done(lat, rdy);
        check("shr_res", aluResult, 8'h10);
        check("shr_carry", Carry, 0);
        drain();

        out_ready = 1'b0;
        issue(4'd5, 8'd3, 8'd5);
        wait_done(lat, rdy);
        check("sub_lat", lat, 1);
        check("sub_res", aluResult, 8'hFE);
        check("sub_carry", Carry, 1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            #1;
            check("sub_hold", {out_valid, in_ready, aluResult, Carry}, {1'b1, 1'b0, 8'hFE, 1'b1});
        end
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        check("sub_release", {out_valid, in_ready}, 2'b01);

        issue(4'd3, 8'h10, 8'h10);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("abort_valid", out_valid, 0);
        check("abort_ready", in_ready, 1);
        check("abort_result", {aluResultHi, aluResult}, 0);
        check("abort_flags", {Zero, Carry, Error}, 0);
        seen = 0;
        repeat (12) begin
            @(posedge clock);
            #1;
            if (out_valid) seen++;
        end
        check("abort_no_result", seen, 0);

        issue(4'hC, 8'hFF, 8'hFF);
        wait_done(lat, rdy);
        check("ill_res", {aluResultHi, aluResult}, 0);
        check("ill_flags", {Zero, Carry, Error}, 3'b101);
        drain();

        issue(4'd0, 8'hF0, 8'h3C);
        wait_done(lat, rdy);
        check("and_res", aluResult, 8'h30);
        check("and_flags", {Zero, Carry, Error}, 3'b000);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
